square_function: RTL and testbench
==================================

# square_function

Sequential 16-bit unsigned integer squarer, the inverse of the `sqrt_function` core. It accepts a value on a `ce` start strobe, computes `x_in * x_in` with one shift-add step per cycle, and returns a full-precision 32-bit result with a one-cycle `rdy` pulse. It sits beside `sqrt_function` in the magnitude/distance path, where it round-trip checks root results and squares coordinate deltas before they are summed and rooted.

## Interface

Parameters:
- `WIDTH`, default 16: input operand width. Result width is 2*`WIDTH`.

Ports:
- `clk`, input, 1: single system clock; all logic is on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `ce`, input, 1: start strobe. Sampled only while idle.
- `x_in`, input, `WIDTH`: unsigned operand. Captured on the accepting edge.
- `x_out`, output, 2*`WIDTH`: unsigned square. Registered; holds until the next completion.
- `rdy`, output, 1: one-cycle pulse marking that `x_out` has just been updated.
- `busy`, output, 1: high while a computation is in flight.

## Operation

- States:
  - IDLE: waiting for a start.
  - CALC: iterating, with counter `cnt` running 0..`WIDTH`-1.
- IDLE, `ce`=1 at an edge:
  - `mcand <= {WIDTH'b0, x_in}` (2*`WIDTH` wide).
  - `mplier <= x_in`.
  - `acc <= 0`, `cnt <= 0`.
  - `busy <= 1`; go to CALC.
- IDLE, `ce`=0: no state change.
- CALC, each edge:
  - If `mplier[0]`, then `acc <= acc + mcand`.
  - `mcand <= mcand << 1`; `mplier <= mplier >> 1`; `cnt <= cnt + 1`.
- CALC with `cnt`=`WIDTH`-1:
  - The final step's sum is written directly to `x_out`.
  - `rdy <= 1`, `busy <= 0`; go to IDLE.
- Arithmetic:
  - `acc` is 2*`WIDTH` bits wide. The result is exact, so no overflow is possible ((2^W−1)^2 < 2^(2W)).
  - No rounding and no saturation.
- `ce` while in CALC is ignored. There is no queueing and no error flag.
- `x_in` changes after the accepting edge have no effect on the result in flight.
- `rdy` is deasserted on every edge where completion does not occur.

## Timing

- Reset (`reset_n`=0 at an edge), from any state, including mid-CALC:
  - State goes to IDLE.
  - `x_out`=0, `rdy`=0, `busy`=0.
  - `acc`, `mcand`, `mplier` and `cnt` are all cleared.
  - The in-flight result is discarded; no `rdy` is produced for it.
- Reset has priority over `ce` on the same edge.
- Latency: if `ce` is accepted at edge E0, `busy` is high from E0 until E0+`WIDTH`. `rdy` and the new `x_out` are asserted at edge E0+`WIDTH` (16 cycles) and `rdy` falls at E0+`WIDTH`+1.
- `ce`=1 at edge E0+`WIDTH` is ignored, because the state was CALC at that edge.
- `ce`=1 at edge E0+`WIDTH`+1 is accepted.
- Maximum throughput is one result per `WIDTH`+1 cycles.
- `ce` held high continuously restarts the block at every IDLE edge, giving back-to-back operations at 17-cycle spacing.
- `x_out` is stable between `rdy` pulses. It is never an intermediate value.

## Test plan

- Reset check: hold `reset_n`=0 for 5 cycles, then release -> `x_out`=0, `rdy`=0, `busy`=0. With no `ce`, nothing changes for 50 cycles.
- Nominal: `x_in`=18639 with a 1-cycle `ce` -> `rdy` pulses exactly 16 cycles after the accepting edge, with `x_out`=347412321. `busy` is high for exactly 16 cycles.
- Corner values, one at a time:
  - 0 -> 0
  - 1 -> 1
  - 255 -> 65025
  - 65535 -> 4294836225
  - In every case `rdy` is a single-cycle pulse.
- Ignored start and input change: start 136, then pulse `ce` with `x_in`=500 at cycles 3 and 16 after acceptance, and change `x_in` mid-CALC -> one `rdy`, `x_out`=18496. A `ce` at cycle 17 is accepted and yields 250000.
- Back-to-back: `ce` held high with `x_in` stepping through 3, 7, 9 after each acceptance -> `rdy` pulses 17 cycles apart, giving 9, 49, 81.
- Reset mid-operation: start 1000, assert `reset_n`=0 at cycle 8 for one cycle -> no `rdy` for that operation, and `x_out` is 0. A fresh start of 1000 then yields 1000000 after 16 cycles.

Source files
------------

// File: rtl/square_function_if.sv
// rtl/square_function_if.sv - start/result handshake bundle for the sequential squarer
interface square_function_if #(
  parameter int WIDTH = 16
);
  logic                   ce;
  logic [WIDTH-1:0]       x_in;
  logic [2*WIDTH-1:0]     x_out;
  logic                   rdy;
  logic                   busy;

  modport master (
    output ce,
    output x_in,
    input  x_out,
    input  rdy,
    input  busy
  );

  modport slave (
    input  ce,
    input  x_in,
    output x_out,
    output rdy,
    output busy
  );
endinterface

// File: rtl/square_function.sv
// rtl/square_function.sv - shift-add unsigned squarer, one multiplier bit per cycle
module square_function #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  square_function_if.slave sq
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   sum;

  // The last step's sum goes straight to x_out so x_out never shows a partial product.
  always_comb begin
    sum = acc;
    if (mplier[0]) begin
      sum = acc + mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      sq.x_out <= '0;
      sq.rdy   <= 1'b0;
      sq.busy  <= 1'b0;
    end else begin
      sq.rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (sq.ce) begin
            mcand   <= {{WIDTH{1'b0}}, sq.x_in};
            mplier  <= sq.x_in;
            acc     <= '0;
            cnt     <= '0;
            sq.busy <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sq.x_out <= sum;
            sq.rdy   <= 1'b1;
            sq.busy  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_function.sv
// tb/tb_square_function.sv - scoreboard bench for square_function with directed vectors
module tb_square_function;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_rdy = 1'b0;
  exp_t exp_q[$];

  square_function_if #(.WIDTH(16)) sq ();

  square_function #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sq      (sq.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rdy pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && sq.rdy) begin
      checks++;
      if (prev_rdy) begin
        failures++;
        $display("FAIL rdy_pulse: rdy high on consecutive cycles at cycle %0d, required single-cycle", cyc);
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rdy: rdy at cycle %0d x_out=%0d, required no rdy", cyc, sq.x_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (sq.x_out !== e.val) begin
          failures++;
          $display("FAIL x_out: got %0d, required %0d", sq.x_out, e.val);
        end
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL rdy_cycle: rdy at cycle %0d, required %0d", cyc, e.cyc);
        end
      end
    end
    prev_rdy <= sq.rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // One-cycle ce pulse from idle; returns the accepting edge number.
  task automatic start(input logic [15:0] v, input logic [31:0] want, input bit expect_rdy,
                       output int e0);
    exp_t e;
    sq.ce   = 1'b1;
    sq.x_in = v;
    tick(1);
    e0 = cyc;
    sq.ce = 1'b0;
    if (expect_rdy) begin
      e.val = want;
      e.cyc = e0 + 16;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1);
      if (exp_q.size() == 0 && !sq.busy && !sq.rdy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wait_idle: timeout with %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    int e0;
    int nb;
    int bad;
    exp_t e;

    sq.ce   = 1'b0;
    sq.x_in = '0;
    reset_n = 1'b0;
    tick(5);
    check("reset_x_out", sq.x_out, 32'd0);
    check("reset_rdy", {31'd0, sq.rdy}, 32'd0);
    check("reset_busy", {31'd0, sq.busy}, 32'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (sq.busy || sq.rdy || sq.x_out != 32'd0) bad++;
    end
    check("idle_50_cycles", bad, 32'd0);

    // Nominal, with busy duration measured
    start(16'd18639, 32'd347412321, 1'b1, e0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (sq.busy) nb++;
      tick(1);
    end
    check("busy_cycles", nb, 32'd16);
    wait_idle();
    check("x_out_hold", sq.x_out, 32'd347412321);

    start(16'd0, 32'd0, 1'b1, e0);
    wait_idle();
    start(16'd1, 32'd1, 1'b1, e0);
    wait_idle();
    start(16'd255, 32'd65025, 1'b1, e0);
    wait_idle();
    start(16'd65535, 32'd4294836225, 1'b1, e0);
    wait_idle();

    // Ignored starts and input change during CALC
    start(16'd136, 32'd18496, 1'b1, e0);
    tick(2);
    sq.ce = 1'b1;
    sq.x_in = 16'd500;
    tick(1);
    sq.ce = 1'b0;
    sq.x_in = 16'd77;
    tick(12);
    sq.ce = 1'b1;
    sq.x_in = 16'd500;
    tick(1);
    check("ignored_ce_x_out", sq.x_out, 32'd18496);
    tick(1);
    sq.ce = 1'b0;
    e.val = 32'd250000;
    e.cyc = e0 + 17 + 16;
    exp_q.push_back(e);
    wait_idle();

    // Back-to-back with ce held high
    sq.ce = 1'b1;
    sq.x_in = 16'd3;
    tick(1);
    e0 = cyc;
    e.val = 32'd9;
    e.cyc = e0 + 16;
    exp_q.push_back(e);
    sq.x_in = 16'd7;
    tick(17);
    e.val = 32'd49;
    e.cyc = e0 + 17 + 16;
    exp_q.push_back(e);
    sq.x_in = 16'd9;
    tick(17);
    e.val = 32'd81;
    e.cyc = e0 + 34 + 16;
    exp_q.push_back(e);
    sq.ce = 1'b0;
    wait_idle();

    // Reset mid-operation discards the result
    start(16'd1000, 32'd1000000, 1'b0, e0);
    tick(7);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("midreset_x_out", sq.x_out, 32'd0);
    check("midreset_busy", {31'd0, sq.busy}, 32'd0);
    tick(20);
    check("midreset_no_result", sq.x_out, 32'd0);
    start(16'd1000, 32'd1000000, 1'b1, e0);
    wait_idle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
